// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for one serial frame; flags the last bit position.
module piso_bit_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_lr.sv
// Serialises a WIDTH-bit word one bit per clock, LSB-first or MSB-first,
// with frame valid/busy/done signalling and zero-gap back-to-back reloads.
module piso_lr
  import piso_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic             dir_q;
  logic             last;
  logic             shifting;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;

  assign shifting = (state == SHIFT);
  // A load is only honoured from IDLE or on the last bit of a running frame.
  assign accept    = load && (!shifting || last);
  assign cnt_clear = accept || (shifting && last);
  assign cnt_en    = shifting && !last;

  piso_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .last   (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg  <= '0;
      dir_q <= DIR_LSB_FIRST;
    end else if (accept) begin
      sreg  <= data_in;
      dir_q <= dir;
    end else if (shifting) begin
      // Move the next bit toward the emitting end, zero-filling behind it.
      if (dir_q == DIR_MSB_FIRST) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
        sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    data_out = 1'b0;
    valid    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (shifting) begin
      data_out = (dir_q == DIR_MSB_FIRST) ? sreg[WIDTH-1] : sreg[0];
      valid    = 1'b1;
      busy     = 1'b1;
      done     = last;
    end
  end

endmodule

// File: tb/tb_piso_lr.sv
// Scoreboard bench for piso_lr: stimulus queues expected bits, a negedge
// monitor pops one entry for every cycle the DUT asserts valid.
module tb_piso_lr;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         load;
  logic         dir;
  logic [W-1:0] data_in;
  logic         data_out;
  logic         valid;
  logic         busy;
  logic         done;

  int tests_run = 0;
  int tests_failed = 0;
  logic mon_on = 1'b0;

  // Each entry: {expected data_out, expected done}
  logic [1:0] sb[$];

  piso_lr #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .dir      (dir),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] w, input logic d);
    for (int i = 0; i < W; i++) begin
      logic b;
      b = d ? w[W-1-i] : w[i];
      sb.push_back({b, (i == W - 1) ? 1'b1 : 1'b0});
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (mon_on) begin
      if (valid) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_bit: got data_out=%0b done=%0b, expected no frame", data_out, done);
        end else begin
          logic [1:0] e;
          e = sb.pop_front();
          chk("data_out", {31'd0, data_out}, {31'd0, e[1]});
          chk("done", {31'd0, done}, {31'd0, e[0]});
          chk("busy_in_frame", {31'd0, busy}, 32'd1);
        end
      end else begin
        chk("idle_outputs", {29'd0, data_out, busy, done}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    dir     = 1'b0;
    data_in = '0;

    // Reset held two cycles, outputs all 0
    tick();
    mon_on = 1'b1;
    chk("reset_c1", {28'd0, data_out, valid, busy, done}, 32'd0);
    tick();
    chk("reset_c2", {28'd0, data_out, valid, busy, done}, 32'd0);
    reset = 1'b0;
    tick();

    // LSB-first 1011 -> 1,1,0,1
    load = 1'b1; dir = 1'b0; data_in = 4'b1011;
    push_frame(4'b1011, 1'b0);
    tick();
    load = 1'b0;
    repeat (W) tick();
    chk("idle_after_lsb", {31'd0, busy}, 32'd0);
    tick();

    // MSB-first 1011 -> 1,0,1,1 with dir toggling mid-frame
    load = 1'b1; dir = 1'b1; data_in = 4'b1011;
    push_frame(4'b1011, 1'b1);
    tick();
    load = 1'b0;
    for (int i = 0; i < W; i++) begin
      dir = ~dir;
      data_in = ~data_in;
      tick();
    end
    chk("idle_after_msb", {31'd0, valid}, 32'd0);
    tick();

    // Back-to-back frames: 1100 then 0011, LSB-first, no gap
    load = 1'b1; dir = 1'b0; data_in = 4'b1100;
    push_frame(4'b1100, 1'b0);
    push_frame(4'b0011, 1'b0);
    tick();
    data_in = 4'b0011;
    for (int i = 0; i < 2 * W; i++) begin
      chk("b2b_valid", {31'd0, valid}, 32'd1);
      if (i == W - 1) begin
        tick();
        load = 1'b0;
      end else begin
        tick();
      end
    end
    chk("b2b_end_valid", {31'd0, valid}, 32'd0);
    tick();

    // Load pulsed on the 2nd bit is ignored
    load = 1'b1; dir = 1'b0; data_in = 4'b0101;
    push_frame(4'b0101, 1'b0);
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; data_in = 4'b1111;
    tick();
    load = 1'b0;
    repeat (W) tick();
    chk("no_second_frame", {31'd0, busy}, 32'd0);
    repeat (2) tick();

    // Reset on the 3rd bit aborts the frame
    load = 1'b1; dir = 1'b0; data_in = 4'b1010;
    sb.push_back(2'b00);
    sb.push_back(2'b10);
    sb.push_back(2'b00);
    tick();
    load = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    load = 1'b1; data_in = 4'b1111;
    tick();
    chk("abort_outputs", {28'd0, data_out, valid, busy, done}, 32'd0);
    reset = 1'b0;
    load = 1'b0;
    tick();
    chk("abort_stays_idle", {31'd0, valid}, 32'd0);

    // Fresh frame after abort: 0110 -> 0,1,1,0
    load = 1'b1; dir = 1'b0; data_in = 4'b0110;
    push_frame(4'b0110, 1'b0);
    tick();
    load = 1'b0;
    repeat (W + 2) tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
